// File: rtl/pipelined_multiplexer_n_to_1_if.sv
// Bundle of the select, data and valid/ready handshake signals for pipelined_multiplexer_n_to_1.
// Sel_Error_o exists only when MUX_SELECTOR_ERROR_EN is defined.
interface pipelined_multiplexer_n_to_1_if #(
    parameter int NBits   = 32,
    parameter int NInputs = 4
);
    localparam int SelBits = (NInputs > 1) ? $clog2(NInputs) : 1;

    logic                       Mode_i;
    logic [SelBits-1:0]         Selector_i;
    logic [NInputs*NBits-1:0]   Mux_Data_i;
    logic [NInputs-1:0]         Valid_i;
    logic [NInputs-1:0]         Ready_o;
    logic [NBits-1:0]           Mux_Output_o;
    logic [SelBits-1:0]         Grant_o;
    logic                       Valid_o;
    logic                       Ready_i;
`ifdef MUX_SELECTOR_ERROR_EN
    logic                       Sel_Error_o;
`endif

    modport slave (
        input  Mode_i,
        input  Selector_i,
        input  Mux_Data_i,
        input  Valid_i,
        input  Ready_i,
        output Ready_o,
        output Mux_Output_o,
        output Grant_o,
`ifdef MUX_SELECTOR_ERROR_EN
        output Sel_Error_o,
`endif
        output Valid_o
    );

    modport master (
        output Mode_i,
        output Selector_i,
        output Mux_Data_i,
        output Valid_i,
        output Ready_i,
        input  Ready_o,
        input  Mux_Output_o,
        input  Grant_o,
`ifdef MUX_SELECTOR_ERROR_EN
        input  Sel_Error_o,
`endif
        input  Valid_o
    );
endinterface

// File: rtl/pipelined_multiplexer_n_to_1.sv
// N-to-1 mux with one registered output stage, fixed or round-robin selection and valid/ready flow control.
// Optional macro MUX_SELECTOR_ERROR_EN adds a registered out-of-range selector flag (Sel_Error_o).
module pipelined_multiplexer_n_to_1 #(
    parameter int NBits   = 32,
    parameter int NInputs = 4
) (
    input logic                         clk,
    input logic                         reset,
    pipelined_multiplexer_n_to_1_if.slave bus
);
    localparam int SelBits = (NInputs > 1) ? $clog2(NInputs) : 1;

    logic [NBits-1:0]   r_data;
    logic [SelBits-1:0] r_grant;
    logic               r_valid;
    logic [SelBits-1:0] r_lastGrant;

    logic               w_load;
    logic               w_fixInRange;
    logic               w_rrFound;
    logic [SelBits-1:0] w_rrCh;
    logic [SelBits-1:0] w_ch;
    logic               w_chSel;
    logic               w_chValid;
    logic [NBits-1:0]   w_chData;
    logic               w_xfer;

    assign w_load       = !r_valid || bus.Ready_i;
    assign w_fixInRange = int'(bus.Selector_i) < NInputs;

    // Round-robin: first valid channel scanning upward from the one after the last grant, with wrap.
    always_comb begin
        w_rrFound = 1'b0;
        w_rrCh    = '0;
        for (int off = 1; off <= NInputs; off++) begin
            for (int k = 0; k < NInputs; k++) begin
                if (!w_rrFound && (k == (int'(r_lastGrant) + off) % NInputs) && bus.Valid_i[k]) begin
                    w_rrFound = 1'b1;
                    w_rrCh    = SelBits'(k);
                end
            end
        end
    end

    assign w_ch    = bus.Mode_i ? w_rrCh : bus.Selector_i;
    assign w_chSel = bus.Mode_i ? w_rrFound : w_fixInRange;

    // Compare-based select keeps an out-of-range selector from indexing past the channel vectors.
    always_comb begin
        w_chValid   = 1'b0;
        w_chData    = '0;
        bus.Ready_o = '0;
        for (int k = 0; k < NInputs; k++) begin
            if (int'(w_ch) == k) begin
                w_chValid      = bus.Valid_i[k];
                w_chData       = bus.Mux_Data_i[k*NBits +: NBits];
                bus.Ready_o[k] = reset && w_load && w_chSel;
            end
        end
    end

    assign w_xfer = w_load && w_chSel && w_chValid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data      <= '0;
            r_grant     <= '0;
            r_valid     <= 1'b0;
            r_lastGrant <= SelBits'(NInputs - 1);
        end else if (w_load) begin
            if (w_xfer) begin
                r_data  <= w_chData;
                r_grant <= w_ch;
                r_valid <= 1'b1;
                if (bus.Mode_i) begin
                    r_lastGrant <= w_ch;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.Mux_Output_o = r_data;
    assign bus.Grant_o      = r_grant;
    assign bus.Valid_o      = r_valid;

`ifdef MUX_SELECTOR_ERROR_EN
    logic r_selError;

    // Flags a valid request stalled behind an out-of-range fixed selector; independent of back-pressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_selError <= 1'b0;
        end else begin
            r_selError <= !bus.Mode_i && !w_fixInRange && (|bus.Valid_i);
        end
    end

    assign bus.Sel_Error_o = r_selError;
`endif
endmodule

// File: tb/tb_pipelined_multiplexer_n_to_1.sv
// Directed testbench for pipelined_multiplexer_n_to_1: a 4-input and a 3-input instance.
// Sel_Error_o is checked when MUX_SELECTOR_ERROR_EN is defined.
module tb_pipelined_multiplexer_n_to_1;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    pipelined_multiplexer_n_to_1_if #(.NBits(32), .NInputs(4)) b4 ();
    pipelined_multiplexer_n_to_1_if #(.NBits(32), .NInputs(3)) b3 ();

    pipelined_multiplexer_n_to_1 #(.NBits(32), .NInputs(4)) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    pipelined_multiplexer_n_to_1 #(.NBits(32), .NInputs(3)) u3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        b4.Mode_i = 1'b0; b4.Selector_i = '0; b4.Valid_i = '0; b4.Ready_i = 1'b1;
        b3.Mode_i = 1'b0; b3.Selector_i = '0; b3.Valid_i = '0; b3.Ready_i = 1'b1;
        for (int k = 0; k < 4; k++) b4.Mux_Data_i[k*32 +: 32] = 32'hA000_0000 + k;
        for (int k = 0; k < 3; k++) b3.Mux_Data_i[k*32 +: 32] = 32'h0000_00C0 + k;
    endtask

    task automatic applyReset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idleAll();
        applyReset();
        b4.Mode_i = 1'b1; b4.Valid_i = 4'b1111;
        tick();
        reset = 1'b0;
        tick();
        tick();
        total++; if (b4.Valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0h expected 0", b4.Valid_o); end
        total++; if (b4.Mux_Output_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %0h expected 0", b4.Mux_Output_o); end
        total++; if (b4.Grant_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_grant: got %0h expected 0", b4.Grant_o); end
        total++; if (b4.Ready_o !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready: got %0h expected 0", b4.Ready_o); end
`ifdef MUX_SELECTOR_ERROR_EN
        total++; if (b4.Sel_Error_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_selerr: got %0h expected 0", b4.Sel_Error_o); end
`endif
        reset = 1'b1;
        #1;
        total++; if (b4.Ready_o !== 4'b0001) begin bad++; $display("[TB] FAIL reset_first_ready: got %0h expected 1", b4.Ready_o); end
        tick();
        total++; if (b4.Grant_o !== 2'd0 || b4.Valid_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_first_grant: got grant %0h valid %0h expected 0 1", b4.Grant_o, b4.Valid_o); end
        total++; if (b4.Mux_Output_o !== 32'hA000_0000) begin bad++; $display("[TB] FAIL reset_first_data: got %0h expected a0000000", b4.Mux_Output_o); end
    endtask

    task automatic test_fixed();
        idleAll();
        applyReset();
        b4.Selector_i = 2'd2;
        b4.Mux_Data_i[2*32 +: 32] = 32'hDEAD_BEEF;
        b4.Valid_i = 4'b0100;
        #1;
        total++; if (b4.Ready_o !== 4'b0100) begin bad++; $display("[TB] FAIL fixed_ready: got %0h expected 4", b4.Ready_o); end
        tick();
        total++; if (b4.Mux_Output_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL fixed_data: got %0h expected deadbeef", b4.Mux_Output_o); end
        total++; if (b4.Grant_o !== 2'd2 || b4.Valid_o !== 1'b1) begin bad++; $display("[TB] FAIL fixed_grant: got grant %0h valid %0h expected 2 1", b4.Grant_o, b4.Valid_o); end
        b4.Valid_i = 4'b0000;
        #1;
        total++; if (b4.Ready_o !== 4'b0100) begin bad++; $display("[TB] FAIL fixed_ready_novalid: got %0h expected 4", b4.Ready_o); end
        tick();
        total++; if (b4.Valid_o !== 1'b0 || b4.Mux_Output_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL fixed_idle: got valid %0h data %0h expected 0 deadbeef", b4.Valid_o, b4.Mux_Output_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0] expGrant [4];
        expGrant = '{2'd0, 2'd1, 2'd3, 2'd0};
        idleAll();
        applyReset();
        b4.Mode_i = 1'b1;
        b4.Valid_i = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (b4.Ready_o !== (4'b0001 << expGrant[i])) begin bad++; $display("[TB] FAIL rr_ready[%0d]: got %0h expected %0h", i, b4.Ready_o, 4'b0001 << expGrant[i]); end
            tick();
            total++; if (b4.Grant_o !== expGrant[i] || b4.Valid_o !== 1'b1) begin bad++; $display("[TB] FAIL rr_grant[%0d]: got grant %0h valid %0h expected %0h 1", i, b4.Grant_o, b4.Valid_o, expGrant[i]); end
            total++; if (b4.Mux_Output_o !== 32'hA000_0000 + 32'(expGrant[i])) begin bad++; $display("[TB] FAIL rr_data[%0d]: got %0h expected %0h", i, b4.Mux_Output_o, 32'hA000_0000 + 32'(expGrant[i])); end
        end
        b4.Valid_i = 4'b0000;
        tick();
    endtask

    task automatic test_back_pressure();
        idleAll();
        applyReset();
        b4.Mode_i = 1'b1;
        b4.Valid_i = 4'b0001;
        b4.Mux_Data_i[0 +: 32] = 32'h1111_1111;
        tick();
        total++; if (b4.Mux_Output_o !== 32'h1111_1111 || b4.Valid_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_first: got data %0h valid %0h expected 11111111 1", b4.Mux_Output_o, b4.Valid_o); end
        b4.Ready_i = 1'b0;
        b4.Mux_Data_i[0 +: 32] = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (b4.Ready_o !== 4'b0000) begin bad++; $display("[TB] FAIL bp_ready[%0d]: got %0h expected 0", i, b4.Ready_o); end
            tick();
            total++; if (b4.Mux_Output_o !== 32'h1111_1111 || b4.Grant_o !== 2'd0 || b4.Valid_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold[%0d]: got data %0h grant %0h valid %0h expected 11111111 0 1", i, b4.Mux_Output_o, b4.Grant_o, b4.Valid_o); end
        end
        b4.Ready_i = 1'b1;
        #1;
        total++; if (b4.Ready_o !== 4'b0001) begin bad++; $display("[TB] FAIL bp_release_ready: got %0h expected 1", b4.Ready_o); end
        tick();
        total++; if (b4.Mux_Output_o !== 32'h2222_2222 || b4.Valid_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_no_bubble: got data %0h valid %0h expected 22222222 1", b4.Mux_Output_o, b4.Valid_o); end
        b4.Valid_i = 4'b0000;
        tick();
    endtask

    task automatic test_out_of_range();
        idleAll();
        applyReset();
        b3.Selector_i = 2'd1;
        b3.Valid_i = 3'b111;
        tick();
        total++; if (b3.Grant_o !== 2'd1 || b3.Valid_o !== 1'b1 || b3.Mux_Output_o !== 32'hC1) begin bad++; $display("[TB] FAIL oor_setup: got grant %0h valid %0h data %0h expected 1 1 c1", b3.Grant_o, b3.Valid_o, b3.Mux_Output_o); end
        b3.Selector_i = 2'd3;
        #1;
        total++; if (b3.Ready_o !== 3'b000) begin bad++; $display("[TB] FAIL oor_ready: got %0h expected 0", b3.Ready_o); end
        tick();
        total++; if (b3.Valid_o !== 1'b0 || b3.Grant_o !== 2'd1 || b3.Mux_Output_o !== 32'hC1) begin bad++; $display("[TB] FAIL oor_drain: got valid %0h grant %0h data %0h expected 0 1 c1", b3.Valid_o, b3.Grant_o, b3.Mux_Output_o); end
`ifdef MUX_SELECTOR_ERROR_EN
        total++; if (b3.Sel_Error_o !== 1'b1) begin bad++; $display("[TB] FAIL oor_selerr_set: got %0h expected 1", b3.Sel_Error_o); end
`endif
        b3.Selector_i = 2'd0;
        #1;
        total++; if (b3.Ready_o !== 3'b001) begin bad++; $display("[TB] FAIL oor_recover_ready: got %0h expected 1", b3.Ready_o); end
        tick();
        total++; if (b3.Valid_o !== 1'b1 || b3.Grant_o !== 2'd0 || b3.Mux_Output_o !== 32'hC0) begin bad++; $display("[TB] FAIL oor_recover: got valid %0h grant %0h data %0h expected 1 0 c0", b3.Valid_o, b3.Grant_o, b3.Mux_Output_o); end
`ifdef MUX_SELECTOR_ERROR_EN
        total++; if (b3.Sel_Error_o !== 1'b0) begin bad++; $display("[TB] FAIL oor_selerr_clear: got %0h expected 0", b3.Sel_Error_o); end
`endif
        b3.Valid_i = 3'b000;
        tick();
    endtask

    task automatic test_mode_switch();
        idleAll();
        applyReset();
        b4.Mode_i = 1'b1;
        b4.Valid_i = 4'b0011;
        tick();
        tick();
        total++; if (b4.Grant_o !== 2'd1) begin bad++; $display("[TB] FAIL ms_rr_grant: got %0h expected 1", b4.Grant_o); end
        b4.Mode_i = 1'b0;
        b4.Selector_i = 2'd0;
        b4.Valid_i = 4'b0001;
        tick();
        total++; if (b4.Grant_o !== 2'd0 || b4.Valid_o !== 1'b1) begin bad++; $display("[TB] FAIL ms_fixed_grant: got grant %0h valid %0h expected 0 1", b4.Grant_o, b4.Valid_o); end
        b4.Mode_i = 1'b1;
        b4.Valid_i = 4'b1111;
        #1;
        total++; if (b4.Ready_o !== 4'b0100) begin bad++; $display("[TB] FAIL ms_back_ready: got %0h expected 4", b4.Ready_o); end
        tick();
        total++; if (b4.Grant_o !== 2'd2 || b4.Mux_Output_o !== 32'hA000_0002) begin bad++; $display("[TB] FAIL ms_back_grant: got grant %0h data %0h expected 2 a0000002", b4.Grant_o, b4.Mux_Output_o); end
        b4.Valid_i = 4'b0000;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idleAll();
        test_reset();
        test_fixed();
        test_round_robin();
        test_back_pressure();
        test_out_of_range();
        test_mode_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
